// File: rtl/lsu_split.sv
// lsu_split: load/store unit front end that turns one RISC-V load or store
// request into one or two word-aligned memory beats.
// A word-crossing access is split into two beats, with byte lanes placed per beat.
// Load bytes are reassembled from both beats and then sign- or zero-extended.
//
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses.
// Without it, any access with addr mod size != 0 completes with rsp_err and
// issues no memory beat.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake; ready only while idle
//   req_store         1 = store, 0 = load
//   req_funct3        RISC-V access type (size / signedness)
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         extended load data (0 for stores and errors)
//   rsp_err           access fault (illegal funct3 or forbidden misalignment)
//   mem_req           beat request, held with addr/we/wdata until mem_gnt
//   mem_addr          word-aligned beat address
//   mem_we            per-byte write enables (0 for loads)
//   mem_wdata         store data placed in its byte lanes
//   mem_gnt           beat accepted
//   mem_rvalid        load data valid, one cycle or more after mem_gnt
//   mem_rdata         load data word
module lsu_split #(
    parameter int XLEN = 32,
    parameter int BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic [BE_W-1:0] mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam int OW = $clog2(BE_W);

    typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;
    state_t state, state_nx;

    logic            st_q, err_q, split_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q, wdata_q, lo_q, hi_q;

    // Request decode, evaluated on the inputs at acceptance.
    logic [3:0] req_sz;
    logic       req_legal, req_mis, req_split;

    always_comb begin
        req_sz    = 4'd1 << req_funct3[1:0];
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_store;
            3'b011:                 req_legal = (XLEN == 64);
            3'b110:                 req_legal = !req_store && (XLEN == 64);
            default:                req_legal = 1'b0;
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        req_mis   = 1'b0;
        req_split = (5'(req_addr[OW-1:0]) + 5'(req_sz)) > 5'(BE_W);
`else
        req_mis   = (req_addr[3:0] & (req_sz - 4'd1)) != 4'd0;
        req_split = 1'b0;
`endif
    end

    // Lane placement for the captured access.
    logic [OW-1:0]     off;
    logic [OW+2:0]     shamt;
    logic [3:0]        sz;
    logic [BE_W-1:0]   sz_be;
    logic [XLEN-1:0]   dmask, raw, load_res, base;
    logic [2*BE_W-1:0] we_wide;
    logic [2*XLEN-1:0] wd_wide, rd_wide;
    logic              sign;

    always_comb begin
        off   = addr_q[OW-1:0];
        shamt = {off, 3'b000};
        sz    = 4'd1 << f3_q[1:0];
        sz_be = '0;
        dmask = '0;
        for (int unsigned i = 0; i < BE_W; i++) begin
            sz_be[i]       = (i < 32'(sz));
            dmask[i*8 +: 8] = {8{sz_be[i]}};
        end
        // Low half feeds beat0, high half feeds beat1 of a split access.
        we_wide = {{BE_W{1'b0}}, sz_be} << off;
        wd_wide = {{XLEN{1'b0}}, wdata_q & dmask} << shamt;
        rd_wide = {hi_q, lo_q} >> shamt;
        raw     = rd_wide[XLEN-1:0] & dmask;
        // dmask ^ (dmask >> 1) isolates the top bit of the access size.
        sign     = |(raw & (dmask ^ (dmask >> 1)));
        load_res = raw | ((sign && !f3_q[2]) ? ~dmask : '0);
        base     = {addr_q[XLEN-1:OW], {OW{1'b0}}};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req_valid) state_nx = BEAT0;
            BEAT0: begin
                if (err_q)          state_nx = RESP;
                else if (mem_gnt) begin
                    if (!st_q)        state_nx = WAIT0;
                    else if (split_q) state_nx = BEAT1;
                    else              state_nx = RESP;
                end
            end
            WAIT0: if (mem_rvalid) state_nx = split_q ? BEAT1 : RESP;
            BEAT1: if (mem_gnt)    state_nx = st_q ? RESP : WAIT1;
            WAIT1: if (mem_rvalid) state_nx = RESP;
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        mem_req   = ((state == BEAT0) || (state == BEAT1)) && !err_q;
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_addr = (state == BEAT1) ? base + XLEN'(BE_W) : base;
            if (st_q) begin
                mem_we    = (state == BEAT1) ? we_wide[2*BE_W-1:BE_W] : we_wide[BE_W-1:0];
                mem_wdata = (state == BEAT1) ? wd_wide[2*XLEN-1:XLEN] : wd_wide[XLEN-1:0];
            end
        end
        rsp_valid = (state == RESP);
        rsp_err   = (state == RESP) && err_q;
        rsp_rdata = ((state == RESP) && !err_q && !st_q) ? load_res : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            st_q    <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                st_q    <= req_store;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= !req_legal || req_mis;
                split_q <= req_legal && req_split;
            end
            if (state == WAIT0 && mem_rvalid) lo_q <= mem_rdata;
            if (state == WAIT1 && mem_rvalid) hi_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_lsu_split.sv
// Testbench for lsu_split (XLEN=32). Directed requests push their expected
// response into a queue; a monitor pops and compares on each rsp_valid.
// Define LSU_MISALIGN_SPLIT_EN for the split vectors; otherwise the
// misalignment-fault vectors run.
module tb_lsu_split;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    lsu_split #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          acc;
        int          lat;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: the rsp_valid seen at this negedge is consumed by the next posedge,
    // so latency counts edges from acceptance up to that edge.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
                chk("rsp_latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
            end
        end
    end

    task automatic wait_mem_req();
        int w = 0;
        while (!mem_req && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("beat_req", 64'(mem_req), 64'd1);
    endtask

    task automatic do_beat(input bit st, input logic [31:0] a, input logic [3:0] we,
                           input logic [31:0] wd, input logic [31:0] rd, input int dly);
        wait_mem_req();
        chk("beat_addr", 64'(mem_addr), 64'(a));
        chk("beat_we", 64'(mem_we), 64'(we));
        chk("beat_wdata", 64'(mem_wdata), 64'(wd));
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            chk("stall_req", 64'(mem_req), 64'd1);
            chk("stall_addr", 64'(mem_addr), 64'(a));
            chk("stall_we", 64'(mem_we), 64'(we));
            chk("stall_wdata", 64'(mem_wdata), 64'(wd));
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        if (!st) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    endtask

    task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int nb,
                       input logic [31:0] a0, input logic [3:0] we0,
                       input logic [31:0] wd0, input logic [31:0] rd0, input int dly,
                       input logic [31:0] a1, input logic [3:0] we1,
                       input logic [31:0] wd1, input logic [31:0] rd1,
                       input bit eerr, input logic [31:0] erd, input int elat);
        exp_t e;
        int w = 0;
        chk("req_ready", 64'(req_ready), 64'd1);
        e.err = eerr; e.rd = erd; e.acc = cyc + 1; e.lat = elat;
        q.push_back(e);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_wdata = '0;
        if (nb == 0) begin
            chk("err_no_memreq", 64'(mem_req), 64'd0);
            @(negedge clk);
            chk("err_no_memreq", 64'(mem_req), 64'd0);
        end
        if (nb >= 1) do_beat(st, a0, we0, wd0, rd0, dly);
        if (nb >= 2) do_beat(st, a1, we1, wd1, rd1, 0);
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("back_to_idle", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);

        //  st  f3      addr          wdata        nb  beat0: addr       we       wdata          rdata         dly  beat1: addr we wdata rdata          err  rdata          lat
        run(1, 3'b010, 32'h100,      32'hDEADBEEF, 1, 32'h100,      4'b1111, 32'hDEADBEEF, 32'h0,        0, 32'h0, 4'b0, 32'h0, 32'h0,             0, 32'h0,         2);
        run(0, 3'b000, 32'h103,      32'h0,        1, 32'h100,      4'b0000, 32'h0,        32'h80112233, 0, 32'h0, 4'b0, 32'h0, 32'h0,             0, 32'hFFFFFF80,  3);
        run(0, 3'b100, 32'h103,      32'h0,        1, 32'h100,      4'b0000, 32'h0,        32'h80112233, 0, 32'h0, 4'b0, 32'h0, 32'h0,             0, 32'h00000080,  3);
        run(0, 3'b001, 32'h102,      32'h0,        1, 32'h100,      4'b0000, 32'h0,        32'h80112233, 0, 32'h0, 4'b0, 32'h0, 32'h0,             0, 32'hFFFF8011,  3);
        run(0, 3'b101, 32'h102,      32'h0,        1, 32'h100,      4'b0000, 32'h0,        32'h80112233, 0, 32'h0, 4'b0, 32'h0, 32'h0,             0, 32'h00008011,  3);
        run(0, 3'b010, 32'h104,      32'h0,        1, 32'h104,      4'b0000, 32'h0,        32'h12345678, 0, 32'h0, 4'b0, 32'h0, 32'h0,             0, 32'h12345678,  3);
        run(1, 3'b000, 32'h101,      32'hFFFFFFA5, 1, 32'h100,      4'b0010, 32'h0000A500, 32'h0,        0, 32'h0, 4'b0, 32'h0, 32'h0,             0, 32'h0,         2);
        run(1, 3'b001, 32'h102,      32'h00001234, 1, 32'h100,      4'b1100, 32'h12340000, 32'h0,        5, 32'h0, 4'b0, 32'h0, 32'h0,             0, 32'h0,         7);
        run(0, 3'b011, 32'h100,      32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 32'h0, 4'b0, 32'h0, 32'h0,             1, 32'h0,         2);
        run(1, 3'b100, 32'h100,      32'h1,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 32'h0, 4'b0, 32'h0, 32'h0,             1, 32'h0,         2);
        run(0, 3'b110, 32'h100,      32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 32'h0, 4'b0, 32'h0, 32'h0,             1, 32'h0,         2);
`ifdef LSU_MISALIGN_SPLIT_EN
        run(0, 3'b010, 32'h0FE,      32'h0,        2, 32'h0FC,      4'b0000, 32'h0,        32'hAABB0000, 0, 32'h100, 4'b0000, 32'h0, 32'h0000CCDD, 0, 32'hCCDDAABB, 5);
        run(1, 3'b001, 32'hFFFFFFFF, 32'h00001234, 2, 32'hFFFFFFFC, 4'b1000, 32'h34000000, 32'h0,        0, 32'h0, 4'b0001, 32'h00000012, 32'h0,    0, 32'h0,         3);
        run(0, 3'b001, 32'h101,      32'h0,        1, 32'h100,      4'b0000, 32'h0,        32'h00ABCD00, 0, 32'h0, 4'b0, 32'h0, 32'h0,             0, 32'hFFFFABCD,  3);
`else
        run(0, 3'b001, 32'h101,      32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 32'h0, 4'b0, 32'h0, 32'h0,             1, 32'h0,         2);
        run(1, 3'b010, 32'h102,      32'hCAFEF00D, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 32'h0, 4'b0, 32'h0, 32'h0,             1, 32'h0,         2);
`endif

        // Reset during WAIT0: no response, and a late rvalid must be ignored.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        wait_mem_req();
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait0_no_req", 64'(mem_req), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_mem_req", 64'(mem_req), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk("late_rvalid_idle", 64'(req_ready), 64'd1);
        chk("late_rvalid_no_req", 64'(mem_req), 64'd0);
        repeat (3) @(negedge clk);

        run(0, 3'b010, 32'h204, 32'h0, 1, 32'h204, 4'b0000, 32'h0, 32'h5A5AA5A5, 0, 32'h0, 4'b0, 32'h0, 32'h0, 0, 32'h5A5AA5A5, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_split.md
LSU_SPLIT -- requirements
Module: lsu_split

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter BE_W, default XLEN/8, byte-enable width; derived, not overridden.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_valid in 1 request valid; req_ready out 1 unit idle; req_store in 1 store(1)/load(0).
REQ-006 SHALL have ports req_funct3 in 3 RV access type; req_addr in XLEN byte address; req_wdata in XLEN store data, right-aligned.
REQ-007 SHALL have ports rsp_valid out 1 completion pulse; rsp_rdata out XLEN extended load data; rsp_err out 1 access fault.
REQ-008 SHALL have ports mem_req out 1 beat request; mem_addr out XLEN word-aligned address; mem_we out BE_W byte write enables; mem_wdata out XLEN lane-positioned data.
REQ-009 SHALL have ports mem_gnt in 1 beat accepted; mem_rvalid in 1 read data valid; mem_rdata in XLEN read word.

Function
REQ-010 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1; req_ready=1 only in state IDLE.
REQ-011 SHALL decode funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011 D and 110 WU only when XLEN=64; stores use 000-011 only; any other code -> rsp_err=1, no mem_req.
REQ-012 SHALL use FSM IDLE -> BEAT0 -> (WAIT0) -> [BEAT1 -> (WAIT1)] -> RESP -> IDLE; WAITn entered only for loads.
REQ-013 SHALL assert mem_req from the cycle after acceptance and hold mem_req, mem_addr, mem_we, mem_wdata stable until mem_gnt=1.
REQ-014 SHALL complete a store beat on mem_gnt; a load beat on mem_rvalid, which arrives no earlier than the cycle after mem_gnt.
REQ-015 SHALL drive mem_we=0 for loads; for stores set mem_we bit i only for bytes written in that beat, mem_wdata shifted to those lanes.
REQ-016 SHALL treat an access as split when (addr mod BE_W)+size > BE_W: beat0 at floor(addr), lanes offset..BE_W-1; beat1 at floor(addr)+BE_W modulo 2^XLEN (wraps at top), lanes 0..remaining-1.
REQ-017 SHALL treat a misaligned access contained in one word as a single beat.
REQ-018 SHALL assemble load bytes from both beats, then sign-extend (B,H,W) or zero-extend (BU,HU,WU) to XLEN.
REQ-019 SHALL pulse rsp_valid for exactly one cycle in RESP; rsp_rdata valid only with rsp_valid for loads, 0 for stores and errors.
REQ-020 SHALL give aligned-load latency acceptance-to-rsp_valid of 3 cycles with zero-wait memory (gnt in first BEAT cycle, rvalid next cycle); split load 5 cycles.
REQ-021 SHALL ignore req_valid while not IDLE; accepting the next request in the cycle after RESP.
REQ-022 SHALL ignore mem_gnt and mem_rvalid outside BEATn/WAITn respectively.

Reset
REQ-023 SHALL on reset enter IDLE within one edge, including mid-transaction, dropping mem_req immediately.
REQ-024 SHALL reset outputs to: req_ready=1 after reset released, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_addr=0, mem_we=0, mem_wdata=0.
REQ-025 SHALL discard any mem_rvalid belonging to a transaction aborted by reset.

Configuration
REQ-026 SHALL with macro LSU_MISALIGN_SPLIT_EN defined perform REQ-016 splitting for word-crossing accesses.
REQ-027 SHALL without LSU_MISALIGN_SPLIT_EN flag any access where addr mod size != 0 with rsp_err=1 in RESP, no mem_req issued, latency 2 cycles.

Verification
REQ-028 SHALL cover: XLEN=32, SW addr 0x100 data 0xDEADBEEF, gnt immediate -> one beat, mem_addr 0x100, mem_we 1111, rsp_valid 2 cycles after accept.
REQ-029 SHALL cover: LB addr 0x103, mem_rdata 0x80112233 -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 SHALL cover (EN defined): LW addr 0x0FE, beat0 rdata 0xAABB0000, beat1 rdata 0x0000CCDD -> beats 0x0FC/0x100, rsp_rdata 0xCCDDAABB.
REQ-031 SHALL cover (EN defined): SH addr 0xFFFFFFFF data 0x1234 -> beat0 0xFFFFFFFC we 1000, beat1 0x00000000 we 0001, wdata lanes 0x34/0x12.
REQ-032 SHALL cover: mem_gnt held low 5 cycles -> mem_req/mem_addr stable; reset asserted in WAIT0 -> next cycle mem_req=0, rsp_valid never asserted, late rvalid ignored.
REQ-033 SHALL cover (EN undefined): LH addr 0x101 -> no mem_req, rsp_valid=1 rsp_err=1 2 cycles after accept; XLEN=32 funct3 011 -> rsp_err=1.
